// File: rtl/led_panel_fb_if.sv
// led_panel_fb_if: write-request bundle shared by the host loader (h_*) and
// the pattern generator (p_*). The controller uses the slave side.
interface led_panel_fb_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    localparam int RW = $clog2(ROWS);

    logic            h_valid;
    logic            h_ready;
    logic [RW-1:0]   h_row;
    logic [COLS-1:0] h_data;
    logic            p_valid;
    logic            p_ready;
    logic [RW-1:0]   p_row;
    logic [COLS-1:0] p_data;

    modport master (
        output h_valid, h_row, h_data, p_valid, p_row, p_data,
        input  h_ready, p_ready
    );

    modport slave (
        input  h_valid, h_row, h_data, p_valid, p_row, p_data,
        output h_ready, p_ready
    );
endinterface

// File: rtl/led_panel_fb_ctrl.sv
// led_panel_fb_ctrl: double-buffered frame buffer for a ROWS x COLS
// single-colour LED panel. Host and pattern writers share the back bank
// through a valid/ready arbiter; a commit swaps banks at the next frame end.
// Optional macro LED_FB_CLEAR_EN: after each swap, zero the new back bank
// one row per cycle before accepting writes again.
module led_panel_fb_ctrl #(
    parameter int ROWS          = 16,
    parameter int COLS          = 16,
    parameter int HOST_PRIORITY = 0,
    localparam int RW           = $clog2(ROWS),
    localparam int CW           = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          reset,
    led_panel_fb_if.slave bus,
    input  logic          commit,
    output logic          commit_pending,
    input  logic          frame_done,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic          rd_bit,
    output logic          front_sel
);
    typedef enum logic [1:0] {
        ACCEPT,
        SWAP_WAIT
`ifdef LED_FB_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t          state, state_next;
    logic [COLS-1:0] mem [2][ROWS];
    logic            rr_host;          // 1 = host won the most recent transfer
    logic            grant_h, grant_p;
    logic            xfer, swap;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_data;

    assign swap    = (state == SWAP_WAIT) && frame_done;
    assign xfer    = grant_h | grant_p;
    assign wr_row  = grant_h ? bus.h_row  : bus.p_row;
    assign wr_data = grant_h ? bus.h_data : bus.p_data;

    assign bus.h_ready = grant_h;
    assign bus.p_ready = grant_p;

`ifdef LED_FB_CLEAR_EN
    logic [RW-1:0] clr_row;
    logic          clr_last;

    assign clr_last = (clr_row == RW'(ROWS - 1));

    // Clear row pointer: restarts at row 0 on every swap
    always_ff @(posedge clk) begin
        if (reset || swap)
            clr_row <= '0;
        else if (state == CLEAR)
            clr_row <= clr_row + 1'b1;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ACCEPT;
        else
            state <= state_next;
    end

    // Next-state: commit arms the swap, frame_done performs it
    always_comb begin
        state_next = state;
        case (state)
            ACCEPT: begin
                if (commit)
                    state_next = SWAP_WAIT;
            end
            SWAP_WAIT: begin
                if (frame_done) begin
`ifdef LED_FB_CLEAR_EN
                    state_next = CLEAR;
`else
                    state_next = ACCEPT;
`endif
                end
            end
`ifdef LED_FB_CLEAR_EN
            CLEAR: begin
                // A commit seen during (or on the last cycle of) the clear
                // goes straight on to wait for the next frame end.
                if (clr_last)
                    state_next = (commit_pending || commit) ? SWAP_WAIT : ACCEPT;
            end
`endif
            default: state_next = ACCEPT;
        endcase
    end

    // Output decode: at most one ready, only while writes are accepted
    always_comb begin
        grant_h = 1'b0;
        grant_p = 1'b0;
        if (state == ACCEPT) begin
            if (bus.h_valid && bus.p_valid) begin
                if (HOST_PRIORITY != 0 || !rr_host)
                    grant_h = 1'b1;
                else
                    grant_p = 1'b1;
            end else begin
                grant_h = bus.h_valid;
                grant_p = bus.p_valid;
            end
        end
    end

    // Banks, display select, commit flag, round-robin history and read port
    always_ff @(posedge clk) begin
        if (reset) begin
            mem            <= '{default: '{default: '0}};
            front_sel      <= 1'b0;
            commit_pending <= 1'b0;
            rd_bit         <= 1'b0;
            rr_host        <= 1'b0;
        end else begin
            rd_bit <= mem[front_sel][rd_row][rd_col];
            if (xfer) begin
                rr_host <= grant_h;
                // Rows outside the frame complete the handshake but land nowhere
                for (int unsigned r = 0; r < ROWS; r++)
                    if (wr_row == RW'(r))
                        mem[~front_sel][r] <= wr_data;
            end
`ifdef LED_FB_CLEAR_EN
            if (state == CLEAR)
                mem[~front_sel][clr_row] <= '0;
`endif
            if (swap) begin
                front_sel      <= ~front_sel;
                commit_pending <= 1'b0;
            end else if (commit && state != SWAP_WAIT) begin
                commit_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_led_panel_fb_ctrl.sv
// tb_led_panel_fb_ctrl: directed and random stimulus against a bank-level
// reference model; a round-robin and a host-priority instance share inputs.
// Honours LED_FB_CLEAR_EN when the design is built with it.
module tb_led_panel_fb_ctrl;
    localparam int ROWS = 16;
    localparam int COLS = 16;
`ifdef LED_FB_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        hv = 1'b0, pv = 1'b0, commit = 1'b0, fd = 1'b0;
    logic [3:0]  hr = '0, pr = '0, rdr = '0, rdc = '0;
    logic [15:0] hd = '0, pd = '0;
    logic        cp_a, rd_a, fs_a, cp_b, rd_b, fs_b;

    led_panel_fb_if #(.ROWS(ROWS), .COLS(COLS)) bus_a ();
    led_panel_fb_if #(.ROWS(ROWS), .COLS(COLS)) bus_b ();

    assign bus_a.h_valid = hv;  assign bus_b.h_valid = hv;
    assign bus_a.h_row   = hr;  assign bus_b.h_row   = hr;
    assign bus_a.h_data  = hd;  assign bus_b.h_data  = hd;
    assign bus_a.p_valid = pv;  assign bus_b.p_valid = pv;
    assign bus_a.p_row   = pr;  assign bus_b.p_row   = pr;
    assign bus_a.p_data  = pd;  assign bus_b.p_data  = pd;

    led_panel_fb_ctrl #(.ROWS(ROWS), .COLS(COLS), .HOST_PRIORITY(0)) dut (
        .clk(clk), .reset(reset), .bus(bus_a), .commit(commit),
        .commit_pending(cp_a), .frame_done(fd), .rd_row(rdr), .rd_col(rdc),
        .rd_bit(rd_a), .front_sel(fs_a)
    );

    led_panel_fb_ctrl #(.ROWS(ROWS), .COLS(COLS), .HOST_PRIORITY(1)) dut_hp (
        .clk(clk), .reset(reset), .bus(bus_b), .commit(commit),
        .commit_pending(cp_b), .frame_done(fd), .rd_row(rdr), .rd_col(rdc),
        .rd_bit(rd_b), .front_sel(fs_b)
    );

    // Reference model: [instance][bank][row]; instance 0 = round-robin, 1 = host priority
    logic [15:0] m_mem [2][2][16];
    bit          m_front, m_pending, m_rr_host;
    int          m_clear_left;
    bit          eh_a, ep_a, eh_b, ep_b;
    logic        obs_h_a, obs_p_a, obs_h_b;
    int          checks = 0;
    int          passed = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_mem[0][0][i] = '0; m_mem[0][1][i] = '0;
            m_mem[1][0][i] = '0; m_mem[1][1][i] = '0;
        end
        m_front = 1'b0; m_pending = 1'b0; m_rr_host = 1'b0; m_clear_left = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; hv = 1'b0; pv = 1'b0; commit = 1'b0; fd = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("rst_front_sel", fs_a, 1'b0);  chk("rst_hp_front_sel", fs_b, 1'b0);
        chk("rst_pending", cp_a, 1'b0);    chk("rst_hp_pending", cp_b, 1'b0);
        chk("rst_rd_bit", rd_a, 1'b0);     chk("rst_hp_rd_bit", rd_b, 1'b0);
        chk("rst_h_ready", bus_a.h_ready, 1'b0);
        chk("rst_p_ready", bus_a.p_ready, 1'b0);
    endtask

    // One clock: check readies before the edge, advance the model, check after
    task automatic tick();
        logic erd_a, erd_b;
        bit   allowed, swap;
        logic back;
        @(negedge clk);
        allowed = !m_pending && (m_clear_left == 0);
        if (allowed && hv && pv) begin
            eh_a = !m_rr_host; ep_a = m_rr_host;
        end else begin
            eh_a = allowed && hv; ep_a = allowed && pv;
        end
        eh_b = allowed && hv;
        ep_b = allowed && pv && !hv;
        obs_h_a = bus_a.h_ready; obs_p_a = bus_a.p_ready; obs_h_b = bus_b.h_ready;
        chk("h_ready", obs_h_a, eh_a);
        chk("p_ready", obs_p_a, ep_a);
        chk("one_ready", obs_h_a & obs_p_a, 1'b0);
        chk("hp_h_ready", obs_h_b, eh_b);
        chk("hp_p_ready", bus_b.p_ready, ep_b);
        erd_a = m_mem[0][m_front][rdr][rdc];
        erd_b = m_mem[1][m_front][rdr][rdc];
        @(posedge clk);
        back = m_front ^ 1'b1;
        swap = m_pending && fd && (m_clear_left == 0);
        if (eh_a || ep_a) begin
            m_mem[0][back][eh_a ? hr : pr] = eh_a ? hd : pd;
            m_rr_host = eh_a;
        end
        if (eh_b || ep_b)
            m_mem[1][back][eh_b ? hr : pr] = eh_b ? hd : pd;
        if (m_clear_left > 0) begin
            m_mem[0][back][4'(ROWS - m_clear_left)] = '0;
            m_mem[1][back][4'(ROWS - m_clear_left)] = '0;
            m_clear_left--;
        end
        if (swap) begin
            m_front = !m_front; m_pending = 1'b0;
            if (CLR) m_clear_left = ROWS;
        end else if (commit) begin
            m_pending = 1'b1;
        end
        #1;
        chk("rd_bit", rd_a, erd_a);          chk("hp_rd_bit", rd_b, erd_b);
        chk("front_sel", fs_a, m_front);     chk("hp_front_sel", fs_b, m_front);
        chk("commit_pending", cp_a, m_pending);
        chk("hp_commit_pending", cp_b, m_pending);
    endtask

    task automatic idle(input int n);
        hv = 1'b0; pv = 1'b0; commit = 1'b0; fd = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Every location reads back zero after reset
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                rdr = 4'(r); rdc = 4'(c);
                tick();
                chk("rst_read", rd_a, 1'b0);
            end

        // Contention: round-robin alternates starting with host; priority always host
        hv = 1'b1; pv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            hr = 4'($urandom); hd = 16'($urandom);
            pr = 4'($urandom); pd = 16'($urandom);
            tick();
            chk("rr_order_h", obs_h_a, (k % 2) == 0);
            chk("rr_order_p", obs_p_a, (k % 2) == 1);
            chk("hp_order", obs_h_b, 1'b1);
        end
        hv = 1'b0; pv = 1'b0;

        // Host row 3 = 8001, commit, swap at frame_done
        hv = 1'b1; hr = 4'd3; hd = 16'h8001;
        tick();
        chk("row3_accepted", obs_h_a, 1'b1);
        hv = 1'b0;
        commit = 1'b1; tick(); commit = 1'b0;
        fd = 1'b1; rdr = 4'd3; rdc = 4'd0;
        tick();
        fd = 1'b0;
        chk("swap_front_sel", fs_a, 1'b1);
        chk("swap_edge_read_old", rd_a, 1'b0);
        tick(); chk("row3_col0", rd_a, 1'b1);
        rdc = 4'd15; tick(); chk("row3_col15", rd_a, 1'b1);
        rdc = 4'd1;  tick(); chk("row3_col1", rd_a, 1'b0);
        idle(20);

        // Repeated commits while pending: readies held off, one toggle only
        commit = 1'b1; tick(); commit = 1'b0;
        hv = 1'b1; pv = 1'b1; hr = 4'($urandom); pr = 4'($urandom);
        for (int k = 0; k < 3; k++) begin
            commit = 1'b1; tick(); commit = 1'b0;
            chk("pend_h_ready", obs_h_a, 1'b0);
            tick();
            chk("pend_p_ready", obs_p_a, 1'b0);
            chk("pend_flag", cp_a, 1'b1);
        end
        hv = 1'b0; pv = 1'b0;
        fd = 1'b1; tick(); fd = 1'b0;
        chk("single_toggle", fs_a, 1'b0);
        idle(20);
        fd = 1'b1; tick(); fd = 1'b0;
        chk("fd_not_pending", fs_a, 1'b0);
        idle(20);

        // commit together with frame_done: swap deferred to the next frame end
        commit = 1'b1; fd = 1'b1; tick(); commit = 1'b0; fd = 1'b0;
        chk("same_cycle_no_swap", fs_a, 1'b0);
        chk("same_cycle_pending", cp_a, 1'b1);
        tick();
        fd = 1'b1; tick(); fd = 1'b0;
        chk("deferred_swap", fs_a, 1'b1);
        chk("deferred_cleared", cp_a, 1'b0);

        // Random traffic; a requester holds its request until granted
        for (int i = 0; i < 600; i++) begin
            if (!hv || eh_a) begin
                hv = 1'($urandom_range(0, 1)); hr = 4'($urandom); hd = 16'($urandom);
            end
            if (!pv || ep_a) begin
                pv = 1'($urandom_range(0, 1)); pr = 4'($urandom); pd = 16'($urandom);
            end
            commit = ($urandom_range(0, 19) == 0);
            fd     = ($urandom_range(0, 7) == 0);
            rdr = 4'($urandom); rdc = 4'($urandom);
            tick();
        end
        idle(2);
        fd = 1'b1; tick();
        idle(20);

`ifdef LED_FB_CLEAR_EN
        // Clear after swap: readies off for ROWS cycles, old front zeroed
        hv = 1'b1; hr = 4'd5; hd = 16'hFFFF; tick(); hv = 1'b0;
        commit = 1'b1; tick(); commit = 1'b0;
        fd = 1'b1; tick(); fd = 1'b0;
        hv = 1'b1; hr = 4'd9; hd = 16'($urandom);
        for (int k = 0; k < ROWS; k++) begin
            tick();
            chk("clear_h_ready", obs_h_a, 1'b0);
        end
        hv = 1'b0;
        commit = 1'b1; tick(); commit = 1'b0;
        fd = 1'b1; tick(); fd = 1'b0;
        rdr = 4'd5;
        for (int c = 0; c < 16; c++) begin
            rdc = 4'(c);
            tick();
            if (c > 0) chk("clear_row5", rd_a, 1'b0);
        end
        idle(20);
`endif

        // Reset mid-operation discards a pending swap
        commit = 1'b1; tick(); commit = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rdr = 4'($urandom); rdc = 4'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
